// File: rtl/sd_dat_line_phy.sv
// Single-bit SD DAT line PHY: serializes FIFO words onto dat_pin or
// deserializes card frames into the FIFO, for one or several 34-bit frames.
module sd_dat_line_phy (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic        ack_in,
  input  logic        idle_in,
  input  logic [15:0] TIMEOUT_REG,
  input  logic [3:0]  blocks,
  input  logic        writeRead,
  input  logic        multiple,
  inout  wire         dat_pin,
  input  logic [31:0] dataFROMFIFO,
  output logic        readFIFO_enable,
  output logic        writeFIFO_enable,
  output logic [31:0] dataReadToFIFO,
  output logic        complete,
  output logic        timeout_error,
  output logic        frame_error
);

  typedef enum logic [3:0] {
    IDLE, W_POP, W_LOAD, W_SEND, R_WAIT, R_RECV, R_STOP, R_PUSH, WAIT_ACK
  } state_t;

  state_t      state;
  logic [33:0] tx_shift;
  logic        drive_en;
  logic [5:0]  bit_cnt;
  logic [3:0]  block_cnt;
  logic [3:0]  block_total;
  logic [15:0] wait_cnt;
  logic [31:0] rx_word;
  logic        last_block;

  // drive_en is cleared by the async reset, so the pin floats without a clock
  assign dat_pin    = drive_en ? tx_shift[33] : 1'bz;
  assign last_block = (block_cnt == block_total - 4'd1);

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      tx_shift         <= '0;
      drive_en         <= 1'b0;
      bit_cnt          <= '0;
      block_cnt        <= '0;
      block_total      <= 4'd1;
      wait_cnt         <= '0;
      rx_word          <= '0;
      readFIFO_enable  <= 1'b0;
      writeFIFO_enable <= 1'b0;
      dataReadToFIFO   <= '0;
      complete         <= 1'b0;
      timeout_error    <= 1'b0;
      frame_error      <= 1'b0;
    end else if (idle_in) begin
      // abort keeps the error flags so the controller can still inspect them
      state            <= IDLE;
      drive_en         <= 1'b0;
      bit_cnt          <= '0;
      block_cnt        <= '0;
      wait_cnt         <= '0;
      readFIFO_enable  <= 1'b0;
      writeFIFO_enable <= 1'b0;
      complete         <= 1'b0;
    end else begin
      readFIFO_enable  <= 1'b0;
      writeFIFO_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_in) begin
            block_cnt     <= '0;
            block_total   <= (multiple && blocks != 4'd0) ? blocks : 4'd1;
            wait_cnt      <= '0;
            timeout_error <= 1'b0;
            frame_error   <= 1'b0;
            if (writeRead) begin
              state           <= W_POP;
              readFIFO_enable <= 1'b1;
            end else begin
              state <= R_WAIT;
            end
          end
        end
        W_POP: state <= W_LOAD;
        W_LOAD: begin
          tx_shift <= {1'b0, dataFROMFIFO, 1'b1};
          drive_en <= 1'b1;
          bit_cnt  <= '0;
          state    <= W_SEND;
        end
        W_SEND: begin
          if (bit_cnt == 6'd33) begin
            drive_en <= 1'b0;
            if (last_block) begin
              state    <= WAIT_ACK;
              complete <= 1'b1;
            end else begin
              block_cnt       <= block_cnt + 4'd1;
              state           <= W_POP;
              readFIFO_enable <= 1'b1;
            end
          end else begin
            bit_cnt  <= bit_cnt + 6'd1;
            tx_shift <= {tx_shift[32:0], 1'b0};
          end
        end
        R_WAIT: begin
          if (dat_pin == 1'b0) begin
            bit_cnt <= '0;
            state   <= R_RECV;
          end else if (wait_cnt == TIMEOUT_REG) begin
            timeout_error <= 1'b1;
            complete      <= 1'b1;
            state         <= WAIT_ACK;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        R_RECV: begin
          rx_word <= {rx_word[30:0], dat_pin};
          if (bit_cnt == 6'd31) state <= R_STOP;
          else                  bit_cnt <= bit_cnt + 6'd1;
        end
        R_STOP: begin
          if (dat_pin == 1'b0) frame_error <= 1'b1;
          dataReadToFIFO   <= rx_word;
          writeFIFO_enable <= 1'b1;
          state            <= R_PUSH;
        end
        R_PUSH: begin
          if (last_block) begin
            state    <= WAIT_ACK;
            complete <= 1'b1;
          end else begin
            block_cnt <= block_cnt + 4'd1;
            wait_cnt  <= '0;
            state     <= R_WAIT;
          end
        end
        WAIT_ACK: begin
          if (ack_in) begin
            complete <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_line_phy.sv
// Self-checking bench for sd_dat_line_phy: FIFO and card models drive the DUT,
// expected frames/words/timing come from the frame rules computed here.
module tb_sd_dat_line_phy;

  logic        sd_clock = 1'b0;
  logic        reset = 1'b1;
  logic        strobe_in = 1'b0;
  logic        ack_in = 1'b0;
  logic        idle_in = 1'b0;
  logic [15:0] TIMEOUT_REG = 16'd100;
  logic [3:0]  blocks = 4'd0;
  logic        writeRead = 1'b0;
  logic        multiple = 1'b0;
  logic [31:0] dataFROMFIFO = 32'd0;
  wire         dat_pin;
  logic        readFIFO_enable;
  logic        writeFIFO_enable;
  logic [31:0] dataReadToFIFO;
  logic        complete;
  logic        timeout_error;
  logic        frame_error;

  logic        card_en = 1'b0;
  logic        card_bit = 1'b1;
  logic        rfe_prev = 1'b0;
  logic [31:0] fifo_q[$];
  logic [31:0] card_words[$];
  int          checks = 0;
  int          passed = 0;
  int          pops = 0;
  int          pushes = 0;

  assign dat_pin = card_en ? card_bit : 1'bz;
  pullup (dat_pin);

  sd_dat_line_phy dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
    .idle_in(idle_in), .TIMEOUT_REG(TIMEOUT_REG), .blocks(blocks),
    .writeRead(writeRead), .multiple(multiple), .dat_pin(dat_pin),
    .dataFROMFIFO(dataFROMFIFO), .readFIFO_enable(readFIFO_enable),
    .writeFIFO_enable(writeFIFO_enable), .dataReadToFIFO(dataReadToFIFO),
    .complete(complete), .timeout_error(timeout_error), .frame_error(frame_error)
  );

  always #5 sd_clock = ~sd_clock;

  // FIFO model: the popped word is only valid the cycle after the pop pulse
  initial begin
    forever begin
      @(negedge sd_clock);
      if (rfe_prev) begin
        dataFROMFIFO = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
        pops++;
      end else begin
        dataFROMFIFO = $urandom;
      end
      rfe_prev = readFIFO_enable;
      if (writeFIFO_enable === 1'b1) pushes++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_frame(input logic [31:0] w, input logic stop);
    logic [33:0] f;
    f = {1'b0, w, stop};
    for (int k = 0; k < 34; k++) begin
      card_en  = 1'b1;
      card_bit = f[33-k];
      @(negedge sd_clock);
    end
    card_en = 1'b0;
  endtask

  task automatic run_write(input logic [3:0] blk, input logic mul,
                           input logic [31:0] first_word, input string tag);
    logic [31:0] words[$];
    logic [33:0] seen, exp_frame;
    int nb, base_pops;
    nb = mul ? ((blk == 4'd0) ? 1 : int'(blk)) : 1;
    for (int i = 0; i < nb; i++) begin
      words.push_back((i == 0) ? first_word : $urandom);
      fifo_q.push_back(words[i]);
    end
    base_pops = pops;
    writeRead = 1'b1; multiple = mul; blocks = blk; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    for (int b = 0; b < nb; b++) begin
      checks++;
      if (readFIFO_enable !== 1'b1)
        $display("[TB] FAIL %s_pop_pulse blk %0d: got %b expected 1", tag, b, readFIFO_enable);
      else passed++;
      @(negedge sd_clock);
      checks++;
      if ({readFIFO_enable, dat_pin} !== 2'b01)
        $display("[TB] FAIL %s_load_cycle blk %0d: got %b expected 01", tag, b, {readFIFO_enable, dat_pin});
      else passed++;
      for (int k = 0; k < 34; k++) begin
        @(negedge sd_clock);
        seen[33-k] = dat_pin;
      end
      exp_frame = {1'b0, words[b], 1'b1};
      checks++;
      if (seen !== exp_frame)
        $display("[TB] FAIL %s_pin_frame blk %0d: got %h expected %h", tag, b, seen, exp_frame);
      else passed++;
      @(negedge sd_clock);
    end
    checks++;
    if ({complete, dat_pin} !== 2'b11)
      $display("[TB] FAIL %s_complete: got %b expected 11", tag, {complete, dat_pin});
    else passed++;
    checks++;
    if (pops - base_pops !== nb)
      $display("[TB] FAIL %s_pop_count: got %0d expected %0d", tag, pops - base_pops, nb);
    else passed++;
  endtask

  task automatic do_ack(input string tag);
    strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    checks++;
    if ({complete, readFIFO_enable} !== 2'b10)
      $display("[TB] FAIL %s_strobe_ignored: got %b expected 10", tag, {complete, readFIFO_enable});
    else passed++;
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    checks++;
    if (complete !== 1'b0)
      $display("[TB] FAIL %s_ack_release: got %b expected 0", tag, complete);
    else passed++;
    @(negedge sd_clock);
  endtask

  task automatic run_read(input logic [3:0] blk, input logic mul, input int bad_idx, input string tag);
    logic [31:0] got[$];
    logic exp_fe;
    int nb, cyc;
    nb = mul ? ((blk == 4'd0) ? 1 : int'(blk)) : 1;
    exp_fe = (bad_idx >= 0 && bad_idx < nb);
    TIMEOUT_REG = 16'd100; writeRead = 1'b0; multiple = mul; blocks = blk; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    fork
      begin
        repeat ($urandom_range(0, 20)) @(negedge sd_clock);
        for (int i = 0; i < nb; i++) begin
          send_frame(card_words[i], i != bad_idx);
          repeat ($urandom_range(1, 6)) @(negedge sd_clock);
        end
      end
      begin
        cyc = 0;
        while (complete !== 1'b1 && cyc < 2000) begin
          @(negedge sd_clock);
          cyc++;
          if (writeFIFO_enable === 1'b1) got.push_back(dataReadToFIFO);
        end
      end
    join
    checks++;
    if (got.size() !== nb)
      $display("[TB] FAIL %s_push_count: got %0d expected %0d", tag, got.size(), nb);
    else passed++;
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (i >= got.size())
        $display("[TB] FAIL %s_word %0d: got none expected %h", tag, i, card_words[i]);
      else if (got[i] !== card_words[i])
        $display("[TB] FAIL %s_word %0d: got %h expected %h", tag, i, got[i], card_words[i]);
      else passed++;
    end
    checks++;
    if ({complete, timeout_error, frame_error} !== {1'b1, 1'b0, exp_fe})
      $display("[TB] FAIL %s_flags: got %b expected %b", tag,
               {complete, timeout_error, frame_error}, {1'b1, 1'b0, exp_fe});
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sd_clock);
    checks++;
    if ({readFIFO_enable, writeFIFO_enable, complete, timeout_error, frame_error} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {readFIFO_enable, writeFIFO_enable, complete, timeout_error, frame_error});
    else passed++;
    checks++;
    if (dataReadToFIFO !== 32'd0)
      $display("[TB] FAIL reset_data: got %h expected 0", dataReadToFIFO);
    else passed++;
    checks++;
    if (dat_pin !== 1'b1)
      $display("[TB] FAIL reset_pin_released: got %b expected 1", dat_pin);
    else passed++;
    reset = 1'b0;
    @(negedge sd_clock);
  endtask

  task automatic test_single_write();
    run_write(4'd7, 1'b0, 32'hA5A5_0F0F, "single_write");
    do_ack("single_write");
  endtask

  task automatic test_multi_write();
    run_write(4'($urandom_range(2, 4)), 1'b1, $urandom, "multi_write");
    do_ack("multi_write");
    run_write(4'd0, 1'b1, $urandom, "zero_blocks_write");
    do_ack("zero_blocks_write");
  endtask

  task automatic test_frame_error();
    card_words = {$urandom};
    run_read(4'd3, 1'b0, 0, "frame_error");
    do_ack("frame_error");
    checks++;
    if (frame_error !== 1'b1)
      $display("[TB] FAIL frame_error_sticky: got %b expected 1", frame_error);
    else passed++;
  endtask

  task automatic test_multi_read();
    card_words = {32'h0000_1EF4, 32'd1, 32'd2, 32'd3};
    run_read(4'd4, 1'b1, -1, "multi_read");
    do_ack("multi_read");
    card_words = {};
    for (int i = 0; i < 5; i++) card_words.push_back($urandom);
    run_read(4'($urandom_range(2, 5)), 1'b1, $urandom_range(0, 1) == 1 ? 1 : -1, "rand_read");
    do_ack("rand_read");
  endtask

  task automatic test_timeout(input logic [15:0] t);
    int base_push;
    base_push = pushes;
    TIMEOUT_REG = t; writeRead = 1'b0; multiple = 1'b0; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (int'(t)) @(negedge sd_clock);
    checks++;
    if ({timeout_error, complete} !== 2'b00)
      $display("[TB] FAIL timeout_%0d_early: got %b expected 00", t, {timeout_error, complete});
    else passed++;
    @(negedge sd_clock);
    checks++;
    if ({timeout_error, complete} !== 2'b11)
      $display("[TB] FAIL timeout_%0d_rise: got %b expected 11", t, {timeout_error, complete});
    else passed++;
    checks++;
    if (pushes !== base_push)
      $display("[TB] FAIL timeout_%0d_no_push: got %0d expected %0d", t, pushes, base_push);
    else passed++;
    do_ack("timeout");
  endtask

  task automatic test_abort();
    fifo_q.push_back(32'd0);
    writeRead = 1'b1; multiple = 1'b0; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    @(negedge sd_clock);
    repeat (11) @(negedge sd_clock);
    checks++;
    if (dat_pin !== 1'b0)
      $display("[TB] FAIL abort_driving: got %b expected 0", dat_pin);
    else passed++;
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    checks++;
    if ({dat_pin, complete, readFIFO_enable} !== 3'b100)
      $display("[TB] FAIL abort_release: got %b expected 100", {dat_pin, complete, readFIFO_enable});
    else passed++;
    repeat (3) @(negedge sd_clock);
    checks++;
    if ({dat_pin, complete} !== 2'b10)
      $display("[TB] FAIL abort_stays_idle: got %b expected 10", {dat_pin, complete});
    else passed++;
    run_write(4'd0, 1'b0, $urandom, "after_abort");
    do_ack("after_abort");
  endtask

  task automatic test_async_reset();
    card_words = {$urandom | 32'h8000_0001};
    run_read(4'd1, 1'b0, -1, "pre_reset_read");
    do_ack("pre_reset_read");
    writeRead = 1'b0; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      card_en  = 1'b1;
      card_bit = (k == 0) ? 1'b0 : 1'($urandom);
      @(negedge sd_clock);
    end
    #2 reset = 1'b1;
    card_en = 1'b0;
    #1;
    checks++;
    if ({readFIFO_enable, writeFIFO_enable, complete, timeout_error, frame_error} !== 5'b0 ||
        dataReadToFIFO !== 32'd0)
      $display("[TB] FAIL async_reset_read: got %b/%h expected 00000/0",
               {readFIFO_enable, writeFIFO_enable, complete, timeout_error, frame_error}, dataReadToFIFO);
    else passed++;
    @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    fifo_q.push_back(32'd0);
    writeRead = 1'b1; multiple = 1'b0; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (7) @(negedge sd_clock);
    checks++;
    if (dat_pin !== 1'b0)
      $display("[TB] FAIL async_reset_write_driving: got %b expected 0", dat_pin);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dat_pin, complete, readFIFO_enable} !== 3'b100)
      $display("[TB] FAIL async_reset_pin: got %b expected 100", {dat_pin, complete, readFIFO_enable});
    else passed++;
    @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_multi_write();
    test_frame_error();
    test_multi_read();
    test_timeout(16'd100);
    test_timeout(16'd0);
    test_timeout(16'($urandom_range(1, 30)));
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sd_dat_line_phy.md
# sd_dat_line_phy

Single-bit SD DAT line physical layer. It moves 32-bit data blocks between the host data FIFO and the bidirectional `dat_pin`. On a strobe from the DAT controller it either serializes FIFO words onto the pin (write) or deserializes card frames into the FIFO (read), for one block or a programmed number of blocks. It then reports completion and waits for an acknowledge.

## Interface
Parameters: none. All widths are fixed.

Ports:
- `sd_clock` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `strobe_in` in 1: start transfer; sampled only in IDLE.
- `ack_in` in 1: acknowledge of completion; releases WAIT_ACK.
- `idle_in` in 1: synchronous abort to IDLE.
- `TIMEOUT_REG` in 16: read start-bit timeout, in cycles.
- `blocks` in 4: number of blocks when `multiple`=1 (0 is treated as 1).
- `writeRead` in 1: 1 = host-to-card write, 0 = card-to-host read.
- `multiple` in 1: 1 = transfer `blocks` blocks, 0 = exactly one block.
- `dat_pin` inout 1: driven only while transmitting, otherwise high-Z.
- `dataFROMFIFO` in 32: write data, valid the cycle after `readFIFO_enable`.
- `readFIFO_enable` out 1: one-cycle FIFO pop pulse.
- `writeFIFO_enable` out 1: one-cycle FIFO push pulse.
- `dataReadToFIFO` out 32: received word, valid while `writeFIFO_enable`=1.
- `complete` out 1: transfer finished, held until ack.
- `timeout_error` out 1: read start bit not seen in time.
- `frame_error` out 1: received stop bit was 0.

## Operation
- Frame format, both directions: start bit 0, then 32 data bits MSB first, then stop bit 1. One bit per `sd_clock` cycle.
- States: IDLE, W_POP, W_LOAD, W_SEND, R_WAIT, R_RECV, R_STOP, R_PUSH, WAIT_ACK.
- IDLE: `dat_pin` is Z and all pulses are 0.
  - `strobe_in`=1 with `writeRead`=1 goes to W_POP; with `writeRead`=0 it goes to R_WAIT.
  - On that transition: block counter cleared, `timeout_error` and `frame_error` cleared.
- Write path:
  - W_POP: `readFIFO_enable`=1 for one cycle.
  - W_LOAD: latch `dataFROMFIFO` into a 34-bit shift register {0, data, 1}.
  - W_SEND: drive the shift-register MSB for 34 cycles.
  - Block done: if more blocks remain, go to W_POP; else WAIT_ACK.
- Read path:
  - R_WAIT: pin released. A 16-bit counter increments each cycle the sampled pin ≠ 0.
  - Sampled 0 goes to R_RECV.
  - Counter reaching `TIMEOUT_REG` sets `timeout_error`=1 and goes to WAIT_ACK.
  - R_RECV: shift in 32 sampled bits MSB first.
  - R_STOP: sample one bit; a 0 sets `frame_error` (sticky until next strobe).
  - R_PUSH: `writeFIFO_enable`=1 for one cycle with `dataReadToFIFO`=word. More blocks go to R_WAIT (timeout counter reset); else WAIT_ACK.
- Block count: total = `multiple` ? max(`blocks`,1) : 1. Latched at strobe.
- WAIT_ACK: `complete`=1 and pin Z. `ack_in`=1 goes to IDLE with `complete`=0 next cycle.
- `idle_in`=1 in any state forces IDLE next edge. This releases the pin, clears counters and `complete`, and keeps the error flags.
  - Priority: `reset` > `idle_in` > normal flow.
- `strobe_in` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `dat_pin` Z, `readFIFO_enable`=0, `writeFIFO_enable`=0, `dataReadToFIFO`=0, `complete`=0, `timeout_error`=0, `frame_error`=0.
- Write: strobe at edge N; pop pulse during cycle N+1; load at N+2; start bit driven from N+3.
  - Stop bit at N+36.
  - `complete` from N+37 (single block).
- Multi-block write: 36 cycles per block (pop + load + 34 bits).
- Read: data bit 31 is sampled the cycle after the start bit is sampled. The push pulse falls 34 cycles after the start bit is sampled.
- Timeout: with the line held 1, `timeout_error` and `complete` rise `TIMEOUT_REG`+1 cycles after entering R_WAIT.
  - `TIMEOUT_REG`=0 times out immediately, unless the first sample is 0.
- All outputs are registered. Pin samples are not synchronized (same clock domain as the card model).
- Reset mid-transfer: immediate return to reset values; `dat_pin` goes Z asynchronously.

## Test plan
- Single write: FIFO word 0xA5A5_0F0F, `writeRead`=1, `multiple`=0, strobe. Pin shows 0, then 0xA5A50F0F MSB first, then 1. Exactly one pop. `complete` rises; `ack_in` returns to IDLE.
- Multi read: `writeRead`=0, `multiple`=1, `blocks`=4, `TIMEOUT_REG`=100. Card model sends 4 frames carrying 0x1EF4, 1, 2, 3. Exactly 4 push pulses carrying those words, then `complete`=1, `timeout_error`=0.
- Timeout: read with pin pulled to 1 and `TIMEOUT_REG`=100. `timeout_error`=1 and `complete`=1 at cycle 101 after R_WAIT; no push.
- Frame error: read frame whose stop bit is 0. Word still pushed; `frame_error`=1.
- Abort: `idle_in` pulsed mid write bit 10. Pin goes Z next cycle, state IDLE, `complete`=0. A new strobe restarts normally.
- Async reset mid read: all outputs at reset values without waiting for a clock edge. `blocks`=0 with `multiple`=1 transfers exactly 1 block.
